// File: rtl/mux_nto1_arb.sv
// -----------------------------------------------------------------------------
// mux_nto1_arb
//   N-to-1 multiplexer with a single registered output stage and valid/ready
//   handshaking on both sides. The channel is chosen either by an external
//   select (mode=0) or by a round-robin arbiter (mode=1).
//
// Parameters
//   N   number of input channels (>= 2)
//   W   data width per channel
//   SW  channel-index width, derived as $clog2(N)
//
// Ports
//   clk        in   1      clock, rising edge
//   rst        in   1      synchronous reset, active-high
//   mode       in   1      0 = fixed select, 1 = round-robin
//   sel        in   SW     channel used when mode=0
//   in_valid   in   N      per-channel valid
//   in_data    in   N*W    channel i at bits [i*W +: W]
//   in_ready   out  N      per-channel ready (one-hot or zero)
//   out_valid  out  1      output register holds a word
//   out_data   out  W      registered data
//   out_chan   out  SW     channel that supplied out_data
//   xfer_cnt   out  16     accepted-word counter (only with MUX_XFER_CNT_EN)
//   out_ready  in   1      consumer accepts when out_valid & out_ready
//
// Optional feature
//   MUX_XFER_CNT_EN : when defined, adds xfer_cnt, a wrapping count of words
//                     accepted by the consumer.
// -----------------------------------------------------------------------------
module mux_nto1_arb #(
  parameter  int N  = 4,
  parameter  int W  = 8,
  localparam int SW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mode,
  input  logic [SW-1:0]   sel,
  input  logic [N-1:0]    in_valid,
  input  logic [N*W-1:0]  in_data,
  output logic [N-1:0]    in_ready,
  output logic            out_valid,
  output logic [W-1:0]    out_data,
  output logic [SW-1:0]   out_chan,
`ifdef MUX_XFER_CNT_EN
  output logic [15:0]     xfer_cnt,
`endif
  input  logic            out_ready
);

  // Channel index base+k modulo N; k is in 1..N and base < N, so one
  // conditional subtraction is enough.
  function automatic logic [SW-1:0] wrap_idx(input logic [SW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= N) s = s - N;
    return SW'(s);
  endfunction

  logic [W-1:0]  ch_data [N];
  logic [SW-1:0] rr_ptr_reg;
  logic          load;
  logic [SW-1:0] rr_grant;
  logic          rr_found;
  logic          fx_found;
  logic [SW-1:0] grant;
  logic          granted;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_ch
      assign ch_data[gi] = in_data[gi*W +: W];
    end
  endgenerate

  // The output register can take a word when empty or being drained this cycle.
  assign load = ~out_valid | out_ready;

  // Round-robin: first valid channel after the last one granted.
  always_comb begin
    rr_grant = '0;
    rr_found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      if (!rr_found && in_valid[wrap_idx(rr_ptr_reg, k)]) begin
        rr_found = 1'b1;
        rr_grant = wrap_idx(rr_ptr_reg, k);
      end
    end
  end

  // Fixed select: out-of-range selects never grant.
  assign fx_found = (int'(sel) < N) && in_valid[sel];

  assign grant   = mode ? rr_grant : sel;
  assign granted = mode ? rr_found : fx_found;

  // in_ready is held low during reset so no producer believes a word was
  // taken on an edge where the output register is being cleared.
  generate
    for (gi = 0; gi < N; gi++) begin : g_rdy
      assign in_ready[gi] = ~rst & load & granted & (grant == SW'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_chan   <= '0;
      rr_ptr_reg <= SW'(N - 1);
    end else if (load) begin
      if (granted) begin
        out_data  <= ch_data[grant];
        out_chan  <= grant;
        out_valid <= 1'b1;
        // Fixed-select traffic leaves the round-robin position untouched.
        if (mode) rr_ptr_reg <= grant;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef MUX_XFER_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      xfer_cnt <= '0;
    end else if (out_valid && out_ready) begin
      xfer_cnt <= xfer_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mux_nto1_arb.sv
// -----------------------------------------------------------------------------
// tb_mux_nto1_arb
//   Directed bench for mux_nto1_arb (N=4, W=8). The stimulus process pushes the
//   hand-computed expected {chan,data} of every word it expects to be
//   transferred; an independent monitor pops and compares each word the
//   consumer accepts. Handshake and register-state checks are made inline.
// -----------------------------------------------------------------------------
module tb_mux_nto1_arb;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int SW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            mode;
  logic [SW-1:0]   sel;
  logic [N-1:0]    in_valid;
  logic [N*W-1:0]  in_data;
  logic [N-1:0]    in_ready;
  logic            out_valid;
  logic [W-1:0]    out_data;
  logic [SW-1:0]   out_chan;
  logic            out_ready;
`ifdef MUX_XFER_CNT_EN
  logic [15:0]     xfer_cnt;
`endif

  int vectors     = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [SW-1:0] chan;
    logic [W-1:0]  data;
  } exp_t;

  exp_t sb[$];
  logic [W-1:0] chd [N] = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};

  always #5 clk = ~clk;

  mux_nto1_arb #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_chan  (out_chan),
`ifdef MUX_XFER_CNT_EN
    .xfer_cnt  (xfer_cnt),
`endif
    .out_ready (out_ready)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // Scoreboard monitor: every word accepted by the consumer must match the
  // oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL sb_unexpected: got chan %0d data %0h, expected no word", out_chan, out_data);
      end else begin
        e = sb.pop_front();
        check("sb_chan", 32'(out_chan), 32'(e.chan));
        check("sb_data", 32'(out_data), 32'(e.data));
      end
    end
  end

  // One arbitration cycle: ch is the channel expected to be granted (-1 for
  // none). Checks in_ready before the edge and queues the expected word.
  task automatic cyc(input string name, input int ch);
    logic [N-1:0] exp_rdy;
    exp_rdy = (ch >= 0) ? N'(1 << ch) : '0;
    @(negedge clk);
    check({name, "_in_ready"}, 32'(in_ready), 32'(exp_rdy));
    if (ch >= 0) sb.push_back({SW'(ch), chd[ch]});
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    in_data   = {chd[3], chd[2], chd[1], chd[0]};
    rst       = 1'b1;
    mode      = 1'b0;
    sel       = '0;
    in_valid  = 4'b1111;
    out_ready = 1'b1;

    // Reset held two cycles with every channel requesting.
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data",  32'(out_data),  32'd0);
      check("rst_out_chan",  32'(out_chan),  32'd0);
      check("rst_in_ready",  32'(in_ready),  32'd0);
    end
    rst = 1'b0;

    // Fixed select of channel 2.
    sel = 2'd2;
    for (int i = 0; i < 4; i++) cyc("fixed", 2);

    // Round-robin with all channels active, then only 1 and 3.
    mode = 1'b1;
    cyc("rr", 0); cyc("rr", 1); cyc("rr", 2); cyc("rr", 3);
    cyc("rr", 0); cyc("rr", 1);
    in_valid = 4'b1010;
    cyc("rr2", 3); cyc("rr2", 1); cyc("rr2", 3); cyc("rr2", 1);

    // Backpressure on B1.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_in_ready",  32'(in_ready),  32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_out_data",  32'(out_data),  32'hB1);
      check("bp_out_chan",  32'(out_chan),  32'd1);
      tick();
    end
    out_ready = 1'b1;
    cyc("bp_release", 3);
    cyc("bp_release", 1);

    // Fixed channel goes idle while a word is held.
    mode     = 1'b0;
    sel      = 2'd2;
    in_valid = 4'b1111;
    cyc("idle_load", 2);
    out_ready = 1'b0;
    in_valid  = 4'b1011;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("idle_hold_in_ready",  32'(in_ready),  32'd0);
      check("idle_hold_out_valid", 32'(out_valid), 32'd1);
      check("idle_hold_out_data",  32'(out_data),  32'hC2);
      tick();
    end
    out_ready = 1'b1;
    cyc("idle_drain", -1);
    @(negedge clk);
    check("idle_out_valid", 32'(out_valid), 32'd0);
    tick();

    // Round-robin resumes from channel 1, then reset hits a stalled word.
    mode      = 1'b1;
    in_valid  = 4'b1111;
    out_ready = 1'b0;
    @(negedge clk);
    check("midrst_in_ready", 32'(in_ready), 32'b0100);
    tick();  // this C2 is never accepted; reset discards it
    @(negedge clk);
    check("midrst_out_valid", 32'(out_valid), 32'd1);
    check("midrst_out_data",  32'(out_data),  32'hC2);
    check("midrst_stall_rdy", 32'(in_ready),  32'd0);
    tick();
    rst = 1'b1;
    tick();
    check("midrst_rst_valid", 32'(out_valid), 32'd0);
    check("midrst_rst_data",  32'(out_data),  32'd0);
    rst       = 1'b0;
    out_ready = 1'b1;
    cyc("rr_restart", 0); cyc("rr_restart", 1); cyc("rr_restart", 2);
    in_valid = 4'b0000;
    cyc("drain", -1);
    cyc("drain", -1);

`ifdef MUX_XFER_CNT_EN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("cnt_reset", 32'(xfer_cnt), 32'd0);
    mode     = 1'b0;
    sel      = 2'd0;
    in_valid = 4'b0001;
    cyc("cnt_first", 0);
    out_ready = 1'b0;
    in_valid  = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("cnt_stall", 32'(xfer_cnt), 32'd0);
      tick();
    end
    out_ready = 1'b1;
    in_valid  = 4'b0001;
    for (int i = 0; i < 65536; i++) cyc("cnt_run", 0);
    in_valid = 4'b0000;
    cyc("cnt_last", -1);
    @(negedge clk);
    check("cnt_wrap", 32'(xfer_cnt), 32'd1);
    tick();
`endif

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
